// File: rtl/arc4_pkg.sv
// Shared ARC4 sizes and the keystream-generator state encoding.
package arc4_pkg;

    localparam int ARC4_S_DEPTH = 256;
    localparam int ARC4_W       = 8;

    typedef enum logic [3:0] {
        KS_IDLE,
        KS_RD_I,
        KS_CAP_I,
        KS_RD_J,
        KS_CAP_J,
        KS_WR_I,
        KS_WR_J,
        KS_RD_K,
        KS_CAP_K,
        KS_OUT
    } arc4_ks_state_t;

endpackage

// File: rtl/arc4_keystream.sv
// ARC4 PRGA: walks the shared S memory, swaps entries in place and
// streams one keystream byte per step over a valid/ready port.
module arc4_keystream
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ARC4_W-1:0] msg_len,
    output logic              rdy,
    output logic [ARC4_W-1:0] s_addr,
    input  logic [ARC4_W-1:0] s_rddata,
    output logic [ARC4_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ARC4_W-1:0] ks_data,
    output logic              ks_valid,
    input  logic              ks_ready
);

    arc4_ks_state_t    state;
    logic [ARC4_W-1:0] i;
    logic [ARC4_W-1:0] j;
    logic [ARC4_W-1:0] si;
    logic [ARC4_W-1:0] sj;
    logic [ARC4_W-1:0] remaining;
    logic [ARC4_W-1:0] j_nxt;

    assign j_nxt = j + s_rddata;

    // Outputs are registered, so each transition loads the values
    // the next state presents to the memory and the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= KS_IDLE;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            sj        <= '0;
            remaining <= '0;
            rdy       <= 1'b1;
            s_addr    <= '0;
            s_wrdata  <= '0;
            s_wren    <= 1'b0;
            ks_data   <= '0;
            ks_valid  <= 1'b0;
        end else begin
            s_wren <= 1'b0;
            unique case (state)
                KS_IDLE: begin
                    if (en) begin
                        i         <= '0;
                        j         <= '0;
                        remaining <= msg_len;
                        if (msg_len != '0) begin
                            rdy    <= 1'b0;
                            s_addr <= 8'd1;
                            state  <= KS_RD_I;
                        end
                    end
                end
                KS_RD_I: begin
                    i     <= i + 8'd1;
                    state <= KS_CAP_I;
                end
                KS_CAP_I: begin
                    si     <= s_rddata;
                    j      <= j_nxt;
                    s_addr <= j_nxt;
                    state  <= KS_RD_J;
                end
                KS_RD_J: begin
                    state <= KS_CAP_J;
                end
                KS_CAP_J: begin
                    sj       <= s_rddata;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state    <= KS_WR_I;
                end
                KS_WR_I: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                    state    <= KS_WR_J;
                end
                KS_WR_J: begin
                    s_addr <= si + sj;
                    state  <= KS_RD_K;
                end
                KS_RD_K: begin
                    state <= KS_CAP_K;
                end
                KS_CAP_K: begin
                    ks_data  <= s_rddata;
                    ks_valid <= 1'b1;
                    state    <= KS_OUT;
                end
                KS_OUT: begin
                    if (ks_ready) begin
                        ks_valid  <= 1'b0;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            rdy   <= 1'b1;
                            state <= KS_IDLE;
                        end else begin
                            s_addr <= i + 8'd1;
                            state  <= KS_RD_I;
                        end
                    end
                end
                default: begin
                    state <= KS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_keystream.sv
// Directed bench for arc4_keystream with a behavioural S memory
// and a software ARC4 reference for the long run.
module tb_arc4_keystream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] msg_len;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ks_data;
    logic       ks_valid;
    logic       ks_ready;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] got [256];
    logic       ld = 1'b0;
    int         wr_cnt;
    int         total = 0;
    int         passed = 0;

    typedef struct {
        logic [7:0]      len;
        int              st_byte;
        int              st_n;
        bit              pulse;
        logic [2:0][7:0] b;
        int              lat;
        logic [7:0]      s2;
        logic [7:0]      s3;
        logic [7:0]      s5;
    } vec_t;

    vec_t vecs [6];

    arc4_keystream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .msg_len  (msg_len),
        .rdy      (rdy),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren),
        .ks_data  (ks_data),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) begin
            for (int a = 0; a < 256; a++) mem[a] <= img[a];
        end else if (s_wren) begin
            mem[s_addr] <= s_wrdata;
        end
        s_rddata <= mem[s_addr];
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load_img();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic load_ident();
        for (int a = 0; a < 256; a++) img[a] = 8'(a);
        load_img();
    endtask

    task automatic run(input logic [7:0] len, input int st_byte,
                       input int st_n, input bit pulse,
                       output int lat, output int nb);
        int k;
        int stall;
        logic [7:0] held;
        held = '0;
        @(negedge clk);
        msg_len = len;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        k = 1;
        nb = 0;
        stall = 0;
        lat = -1;
        wr_cnt = 0;
        while (k < 4000) begin
            if (rdy) begin
                lat = k;
                break;
            end
            if (s_wren) wr_cnt++;
            if (pulse && (k == 4 || k == 13)) begin
                en = 1'b1;
                msg_len = 8'd7;
            end else begin
                en = 1'b0;
            end
            if (ks_valid) begin
                if (nb == st_byte && stall < st_n) begin
                    ks_ready = 1'b0;
                    if (stall == 0) held = ks_data;
                    else check("stall_hold", int'(ks_data), int'(held));
                    stall++;
                end else begin
                    ks_ready = 1'b1;
                    if (nb < 256) got[nb] = ks_data;
                    nb++;
                end
            end else begin
                ks_ready = ($urandom_range(0, 1) == 1);
            end
            @(posedge clk);
            #1;
            k++;
        end
        en = 1'b0;
        ks_ready = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] len, input int sb,
                                input int sn, input bit p,
                                input logic [23:0] bytes, input int lat,
                                input logic [7:0] s2, input logic [7:0] s3,
                                input logic [7:0] s5);
        vec_t v;
        v.len = len;
        v.st_byte = sb;
        v.st_n = sn;
        v.pulse = p;
        v.b = bytes;
        v.lat = lat;
        v.s2 = s2;
        v.s3 = s3;
        v.s5 = s5;
        return v;
    endfunction

    initial begin
        int lat;
        int nb;
        int n;
        int diffs;
        logic [7:0] key [3];
        logic [7:0] ms [256];
        logic [7:0] mks [255];
        logic [7:0] ii;
        logic [7:0] jj;
        logic [7:0] t;

        rst_n = 1'b0;
        en = 1'b0;
        msg_len = '0;
        ks_ready = 1'b1;

        vecs[0] = mk(3, -1, 0, 0, 24'h070502, 28, 3, 5, 2);
        vecs[1] = mk(3,  1, 5, 0, 24'h070502, 33, 3, 5, 2);
        vecs[2] = mk(0, -1, 0, 0, 24'h000000,  1, 2, 3, 5);
        vecs[3] = mk(3, -1, 0, 1, 24'h070502, 28, 3, 5, 2);
        vecs[4] = mk(1,  0, 2, 0, 24'h000002, 12, 2, 3, 5);
        vecs[5] = mk(2, -1, 0, 0, 24'h000502, 19, 3, 2, 5);

        #12;
        check("rst_rdy", int'(rdy), 1);
        check("rst_ks_valid", int'(ks_valid), 0);
        check("rst_ks_data", int'(ks_data), 0);
        check("rst_s_addr", int'(s_addr), 0);
        check("rst_s_wrdata", int'(s_wrdata), 0);
        check("rst_s_wren", int'(s_wren), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            load_ident();
            run(vecs[v].len, vecs[v].st_byte, vecs[v].st_n,
                vecs[v].pulse, lat, nb);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_nbytes", v), nb, int'(vecs[v].len));
            check($sformatf("v%0d_writes", v), wr_cnt,
                  2 * int'(vecs[v].len));
            for (int b = 0; b < int'(vecs[v].len); b++)
                check($sformatf("v%0d_byte%0d", v, b), int'(got[b]),
                      int'(vecs[v].b[b]));
            check($sformatf("v%0d_S2", v), int'(mem[2]), int'(vecs[v].s2));
            check($sformatf("v%0d_S3", v), int'(mem[3]), int'(vecs[v].s3));
            check($sformatf("v%0d_S5", v), int'(mem[5]), int'(vecs[v].s5));
        end

        // reset asserted during WR_I of the second byte
        load_ident();
        ks_ready = 1'b1;
        @(negedge clk);
        msg_len = 8'd3;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (s_wren) n++;
            if (n == 3) break;
            @(posedge clk);
            #1;
        end
        check("rst_mid_found_wr_i", n, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdy", int'(rdy), 1);
        check("rst_mid_ks_valid", int'(ks_valid), 0);
        check("rst_mid_ks_data", int'(ks_data), 0);
        check("rst_mid_s_addr", int'(s_addr), 0);
        check("rst_mid_s_wrdata", int'(s_wrdata), 0);
        check("rst_mid_s_wren", int'(s_wren), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_ident();
        run(8'd3, -1, 0, 0, lat, nb);
        check("post_rst_latency", lat, 28);
        check("post_rst_nbytes", nb, 3);
        check("post_rst_byte0", int'(got[0]), 8'h02);
        check("post_rst_byte1", int'(got[1]), 8'h05);
        check("post_rst_byte2", int'(got[2]), 8'h07);

        // KSA with key 00 03 3C, then 255 bytes against a software model
        key[0] = 8'h00;
        key[1] = 8'h03;
        key[2] = 8'h3c;
        for (int a = 0; a < 256; a++) img[a] = 8'(a);
        jj = '0;
        for (int a = 0; a < 256; a++) begin
            jj = jj + img[a] + key[a % 3];
            t = img[a];
            img[a] = img[jj];
            img[jj] = t;
        end
        ms = img;
        ii = '0;
        jj = '0;
        for (int m = 0; m < 255; m++) begin
            ii = ii + 8'd1;
            jj = jj + ms[ii];
            t = ms[ii];
            ms[ii] = ms[jj];
            ms[jj] = t;
            t = ms[ii] + ms[jj];
            mks[m] = ms[t];
        end
        load_img();
        run(8'd255, -1, 0, 0, lat, nb);
        check("ksa_latency", lat, 9 * 255 + 1);
        check("ksa_nbytes", nb, 255);
        for (int m = 0; m < 255; m++)
            check($sformatf("ksa_byte%0d", m), int'(got[m]), int'(mks[m]));
        diffs = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ms[a]) diffs++;
        check("ksa_final_S_diffs", diffs, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arc4_keystream.md
# arc4_keystream

Reads the 256-byte ARC4 state array S after the key-scheduling pass has filled it, and runs the pseudo-random generation algorithm (PRGA). It streams one keystream byte per PRGA step over a valid/ready interface and swaps S entries in place in the shared S memory. It sits between the S memory and the XOR/decrypt stage, in the same en/rdy start-protocol family as the init and KSA blocks.

## Interface
Parameters: none. All sizes are fixed by ARC4 (256 entries, 8-bit data).

- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; sampled only while rdy=1
- msg_len  in  8  number of keystream bytes to emit (0–255); captured when en is accepted
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data; synchronous read, valid the cycle after the address
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ks_data  out  8  keystream byte
- ks_valid  out  1  ks_data valid
- ks_ready  in  1  consumer accepts ks_data when ks_valid & ks_ready

## Operation
- Start: en & rdy at a rising edge. On acceptance: i=0, j=0, remaining=msg_len, rdy drops.
  - If msg_len=0, go back to IDLE; rdy=1 the next cycle; no bytes are emitted.
- States per byte, one cycle each except OUT: RD_I → CAP_I → RD_J → CAP_J → WR_I → WR_J → RD_K → CAP_K → OUT.
  - RD_I: i←i+1 (mod 256); s_addr=i+1.
  - CAP_I: si←s_rddata; j←j+s_rddata (mod 256).
  - RD_J: s_addr=j.
  - CAP_J: sj←s_rddata.
  - WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_K: s_addr=si+sj (8-bit wrap).
  - CAP_K: ks_data←s_rddata.
  - OUT: ks_valid=1. Hold until ks_ready. On handshake, remaining−1. If it reaches 0, go to IDLE with rdy=1. Otherwise go to RD_I.
- i==j: both writes store the same value. This is legal and needs no special case.
- s_wren is high only in WR_I and WR_J.
- en while rdy=0 is ignored.
- ks_data and ks_valid stay stable while ks_valid & !ks_ready.

## Timing
- Reset values: rdy=1, ks_valid=0, ks_data=0, s_addr=0, s_wrdata=0, s_wren=0; internal i=j=0, state IDLE.
- Reset mid-operation forces IDLE immediately. No pending write completes after rst_n falls. S contents are then undefined for the consumer.
- First ks_valid rises in the 9th cycle after the en-accept edge.
- With ks_ready tied high:
  - one byte every 9 cycles;
  - rdy returns the cycle after the last handshake.
- Latency from en to rdy with ks_ready=1: 9·msg_len+1 cycles.
- Backpressure of N cycles adds exactly N cycles.
- ks_ready is ignored when ks_valid=0.

## Structure
- Package arc4_pkg holds:
  - the state enum arc4_ks_state_t;
  - ARC4_S_DEPTH=256;
  - ARC4_W=8.
- Single flat module. No sub-module is needed: S memory is external and shared with init/KSA through a top-level mux.

## Test plan
- Identity S (S[k]=k), msg_len=3, ks_ready=1 → bytes 0x02, 0x05, 0x07; final S[2]=3, S[3]=5, S[5]=2; rdy high 28 cycles after en.
- Same setup with ks_ready low for 5 cycles on the second byte → ks_data=0x05 held constant through the stall; total latency 33 cycles.
- msg_len=0 → no ks_valid, no s_wren; rdy returns 1 cycle after en.
- Pulse en twice during a 3-byte run → second pulse ignored; exactly 3 bytes emitted.
- Assert rst_n low during WR_I of byte 2 → all outputs at reset values within the same cycle. A fresh start then behaves normally.
- Init+KSA with key 00 03 3C (SW=10'b1100111100), msg_len=255 → all bytes match a software ARC4 model; final S matches the model.
